// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the 16-bit multicycle MIPS datapath, with a memory-wait timeout.
// Optional retired-instruction counter enabled by `define PERF_CNT_EN.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       Opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             mem_err,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_retired
);

  localparam int unsigned TW    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam bit          TO_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ      = 4'd9,
    S_IMM_EX   = 4'd10,
    S_IMM_WB   = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13,
    S_ERR      = 4'd14
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          wait_st;
  logic          timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and Moore-style control decode; only FETCH looks at mem_ready for outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_cnt_d  = '0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'b00;
    RegDst      = 2'b00;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    mem_err     = 1'b0;
    state_o     = state_q;
    wait_st     = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout     = TO_EN && !mem_ready && (wait_cnt_q == TW'(LIMIT));

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_ERR;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 2'b11;
        op_d    = Opcode;
        case (Opcode)
          3'b000:         state_d = S_RTYPE_EX;
          3'b001, 3'b111: state_d = S_IMM_EX;
          3'b010:         state_d = S_JUMP;
          3'b011:         state_d = S_JAL;
          3'b100, 3'b101: state_d = S_MEMADR;
          default:        state_d = S_BEQ;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        state_d = (op_q == 3'b100) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_ERR;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_ERR;
      end
      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        state_d = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
      end
      S_IMM_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (op_q == 3'b001) ? 2'b10 : 2'b11;
        state_d = S_IMM_WB;
      end
      S_IMM_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
        state_d  = S_FETCH;
      end
      S_ERR:   mem_err = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // Count consecutive non-ready cycles; any exit or ready cycle clears it.
    if (wait_st && !mem_ready) wait_cnt_d = wait_cnt_q + TW'(1);
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] ret_q, ret_d;

  always_comb begin
    ret_d = ret_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
      ret_d = ret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ret_q <= '0;
    else          ret_q <= ret_d;
  end

  assign instr_retired = ret_q;
`else
  assign instr_retired = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed scoreboard bench for mips_multicycle_ctrl (MEM_TIMEOUT=15, CNT_W=4).
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw;
    logic [1:0] m2r, rdst;
    logic       rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       merr;
    logic [3:0] st;
  } ctrl_t;

  typedef struct {
    string      tag;
    ctrl_t      c;
    logic [3:0] ret;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] Opcode = 3'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, mem_err;
  logic [1:0] MemtoReg, RegDst, ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_o;
  logic [3:0] instr_retired;
  ctrl_t      obs;

  int         errors = 0;
  int         checks = 0;
  int         ret_model = 0;
  logic [3:0] prev_st = 4'd0;
  sb_t        sb[$];

  mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .mem_err(mem_err), .state_o(state_o), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, mem_err, state_o};

  // Expected control word for a state, straight from the state table.
  function automatic ctrl_t expv(input logic [3:0] st, input logic rdy, input logic [2:0] op);
    ctrl_t c;
    c    = '0;
    c.st = st;
    case (st)
      4'd1:  begin c.mrd = 1; c.srcb = 2'b01; c.aluop = 2'b11; c.irw = rdy; c.pcw = rdy; end
      4'd2:  begin c.srcb = 2'b11; c.aluop = 2'b11; end
      4'd3:  begin c.srca = 1; c.srcb = 2'b10; c.aluop = 2'b11; end
      4'd4:  begin c.mrd = 1; c.iord = 1; end
      4'd5:  begin c.rw = 1; c.m2r = 2'b01; end
      4'd6:  begin c.mwr = 1; c.iord = 1; end
      4'd7:  begin c.srca = 1; end
      4'd8:  begin c.rw = 1; c.rdst = 2'b01; end
      4'd9:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
      4'd10: begin c.srca = 1; c.srcb = 2'b10; c.aluop = (op == 3'b001) ? 2'b10 : 2'b11; end
      4'd11: begin c.rw = 1; end
      4'd12: begin c.pcw = 1; c.pcsrc = 2'b10; end
      4'd13: begin c.pcw = 1; c.pcsrc = 2'b10; c.rw = 1; c.rdst = 2'b10; c.m2r = 2'b10; end
      4'd14: begin c.merr = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] exp_ret();
`ifdef PERF_CNT_EN
    return 4'(ret_model);
`else
    return 4'd0;
`endif
  endfunction

  task automatic push_exp(input string tag, input logic [3:0] st, input logic rdy, input logic [2:0] op);
    sb_t e;
    if (st == 4'd1 && prev_st != 4'd1 && prev_st != 4'd0) ret_model++;
    prev_st = st;
    e.tag = tag;
    e.c   = expv(st, rdy, op);
    e.ret = exp_ret();
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    sb_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=0 entries expected=1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (obs === e.c) else begin
      errors++;
      $error("FAIL %s ctrl: observed=%h expected=%h", e.tag, obs, e.c);
    end
    checks++;
    assert (instr_retired === e.ret) else begin
      errors++;
      $error("FAIL %s retired: observed=%0d expected=%0d", e.tag, instr_retired, e.ret);
    end
  endtask

  // One clock: drive inputs after the edge, check outputs on the falling edge.
  task automatic cyc(input logic [3:0] st, input logic rdy, input logic [2:0] op, input string tag);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    Opcode    = op;
    push_exp(tag, st, rdy, op);
    @(negedge clk);
    pop_chk();
  endtask

  task automatic do_reset(input string tag);
    reset_n   = 1'b0;
    ret_model = 0;
    prev_st   = 4'd0;
    #1;
    push_exp({tag, "_assert"}, 4'd0, mem_ready, Opcode);
    pop_chk();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_exp({tag, "_idle"}, 4'd0, mem_ready, Opcode);
    @(negedge clk);
    pop_chk();
  endtask

  task automatic run_instr(input logic [2:0] op, input string tag);
    logic [3:0] seq[$];
    case (op)
      3'b000:         seq = '{4'd1, 4'd2, 4'd7, 4'd8};
      3'b001, 3'b111: seq = '{4'd1, 4'd2, 4'd10, 4'd11};
      3'b010:         seq = '{4'd1, 4'd2, 4'd12};
      3'b011:         seq = '{4'd1, 4'd2, 4'd13};
      3'b100:         seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      3'b101:         seq = '{4'd1, 4'd2, 4'd3, 4'd6};
      default:        seq = '{4'd1, 4'd2, 4'd9};
    endcase
    foreach (seq[i]) cyc(seq[i], 1'b1, op, tag);
  endtask

  initial begin
    #1;
    do_reset("por");

    run_instr(3'b000, "rtype");

    cyc(4'd1, 1'b1, 3'b100, "lw_wait");
    cyc(4'd2, 1'b1, 3'b100, "lw_wait");
    cyc(4'd3, 1'b1, 3'b100, "lw_wait");
    repeat (3) cyc(4'd4, 1'b0, 3'b100, "lw_wait");
    cyc(4'd4, 1'b1, 3'b100, "lw_wait");
    cyc(4'd5, 1'b1, 3'b100, "lw_wait");

    cyc(4'd1, 1'b1, 3'b101, "sw_wait");
    cyc(4'd2, 1'b1, 3'b101, "sw_wait");
    cyc(4'd3, 1'b1, 3'b101, "sw_wait");
    repeat (2) cyc(4'd6, 1'b0, 3'b101, "sw_wait");
    cyc(4'd6, 1'b1, 3'b101, "sw_wait");

    run_instr(3'b110, "beq");
    run_instr(3'b001, "slti");
    run_instr(3'b011, "jal");
    run_instr(3'b010, "j");
    run_instr(3'b111, "addi");
    run_instr(3'b100, "lw");

    cyc(4'd1, 1'b1, 3'b100, "mid_rst");
    cyc(4'd2, 1'b1, 3'b100, "mid_rst");
    cyc(4'd3, 1'b1, 3'b100, "mid_rst");
    cyc(4'd4, 1'b0, 3'b100, "mid_rst");
    do_reset("mid_rst");

    repeat (15) cyc(4'd1, 1'b0, 3'b000, "timeout");
    cyc(4'd14, 1'b0, 3'b000, "timeout_err");
    cyc(4'd14, 1'b1, 3'b000, "timeout_sticky");
    cyc(4'd14, 1'b1, 3'b000, "timeout_sticky");
    do_reset("err_rst");

    repeat (14) cyc(4'd1, 1'b0, 3'b000, "late_ready");
    cyc(4'd1, 1'b1, 3'b000, "late_ready");
    cyc(4'd2, 1'b1, 3'b000, "late_ready");
    cyc(4'd7, 1'b1, 3'b000, "late_ready");
    cyc(4'd8, 1'b1, 3'b000, "late_ready");

    do_reset("perf_rst");
    for (int i = 0; i < 17; i++) run_instr(3'($urandom_range(0, 7)), "perf");
    cyc(4'd1, 1'b1, 3'b000, "perf_fetch");
    checks++;
`ifdef PERF_CNT_EN
    assert (instr_retired === 4'd1) else begin
      errors++;
      $error("FAIL perf_wrap: observed=%0d expected=1", instr_retired);
    end
`else
    assert (instr_retired === 4'd0) else begin
      errors++;
      $error("FAIL perf_tied: observed=%0d expected=0", instr_retired);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the 16-bit multicycle MIPS datapath. It takes the instruction opcode and the memory-ready handshake, and it sequences fetch, decode, execute, memory and writeback. It is the producer of the 2-bit ALUOp that the ALU control decoder turns into ALU_Control. It also drives every datapath mux select and write enable.

Parameters:
MEM_TIMEOUT, 15, number of consecutive mem_ready=0 cycles in a wait state before entering ERR; 0 disables the timeout.
CNT_W, 16, width of instr_retired (used only with PERF_CNT_EN).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
Opcode  in  3  IR[15:13]; sampled in DECODE only.
mem_ready  in  1  memory has completed the current read/write this cycle.
PCWrite  out  1  unconditional PC write.
PCWriteCond  out  1  PC write if ALU zero.
IorD  out  1  0 = PC address, 1 = ALUOut address.
MemRead  out  1  memory read request.
MemWrite  out  1  memory write request.
IRWrite  out  1  load instruction register.
MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC.
RegDst  out  2  00 = rt, 01 = rd, 10 = r7.
RegWrite  out  1  register file write.
ALUSrcA  out  1  0 = PC, 1 = regA.
ALUSrcB  out  2  00 = regB, 01 = const 2, 10 = sign-ext imm, 11 = sign-ext imm<<1.
ALUOp  out  2  11 = add, 01 = sub, 10 = slt, 00 = use Function.
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
mem_err  out  1  sticky memory-timeout flag.
state_o  out  4  current state (debug).
instr_retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: asynchronous, state=IDLE(0), op_q=0, wait counter=0, count=0. Every output is 0 while reset_n=0 and in IDLE.
- Outputs are a combinational decode of state. The only input-dependent outputs are IRWrite and PCWrite in FETCH, both gated by mem_ready. Unlisted outputs are 0 in each state.
- IDLE(0): all outputs 0; next FETCH.
- FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=11, PCSource=00, IRWrite=PCWrite=mem_ready. Stay in FETCH while mem_ready=0, else go to DECODE.
- DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=11 (branch target into ALUOut). op_q<=Opcode. Next state by Opcode:
  - 000 -> RTYPE_EX
  - 001 (slti) -> IMM_EX
  - 010 -> JUMP
  - 011 -> JAL
  - 100 (lw) / 101 (sw) -> MEMADR
  - 110 -> BEQ
  - 111 (addi) -> IMM_EX
- MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=11; next MEMRD if op_q=100, else MEMWR.
- MEMRD(4): MemRead=1, IorD=1; wait for mem_ready, then MEMWB.
- MEMWB(5): RegWrite=1, RegDst=00, MemtoReg=01; next FETCH.
- MEMWR(6): MemWrite=1, IorD=1; wait for mem_ready, then FETCH.
- RTYPE_EX(7): ALUSrcA=1, ALUSrcB=00, ALUOp=00; next RTYPE_WB.
- RTYPE_WB(8): RegWrite=1, RegDst=01, MemtoReg=00; next FETCH.
- BEQ(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
- IMM_EX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=11 (addi) or 10 (slti, op_q=001); next IMM_WB.
- IMM_WB(11): RegWrite=1, RegDst=00, MemtoReg=00; next FETCH.
- JUMP(12): PCWrite=1, PCSource=10; next FETCH.
- JAL(13): PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; next FETCH.
- ERR(14): all outputs 0 except mem_err=1; stays in ERR until reset.
- Encoding 15 is unused and goes to IDLE.
- Latency with zero wait states, counted in cycles from FETCH entry:
  - beq, j, jal: 3
  - R-type, addi, slti, sw: 4
  - lw: 5
- Timeout (wait states FETCH/MEMRD/MEMWR):
  - The counter clears on entry to a wait state and increments on each mem_ready=0 cycle.
  - When MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 while mem_ready=0, the next state is ERR. So ERR is entered after exactly MEM_TIMEOUT non-ready cycles.
  - If mem_ready=1 arrives in the same cycle the limit would hit, normal progress wins.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no partial write is completed.

Optional Feature:
PERF_CNT_EN:
- Defined: instr_retired increments by 1 on every transition into FETCH from any state other than IDLE. It wraps modulo 2^CNT_W, resets to 0, and holds its value in ERR.
- Undefined: the instr_retired port still exists, tied to 0, with no counter flops.

Test Plan:
1. Assert reset_n=0 while in MEMRD -> state_o=0 and all outputs 0 in the same cycle. After release: one IDLE cycle, then FETCH with MemRead=1, ALUOp=11.
2. R-type (Opcode=000), mem_ready=1 -> states 1,2,7,8,1. ALUOp=11,11,00 in states 1,2,7. In state 8: RegWrite=1, RegDst=01.
3. lw (100) with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles with IorD=1. Then MEMWB with MemtoReg=01, RegWrite=1; 8 cycles total.
4. MEM_TIMEOUT=15, mem_ready=0 from FETCH entry -> ERR on cycle 16 with mem_err=1, sticky. Repeat with mem_ready=1 on cycle 15 -> DECODE, mem_err=0.
5. beq (110) -> state 9 with PCWriteCond=1, ALUOp=01, PCSource=01. slti (001) -> state 10 with ALUOp=10. jal (011) -> state 13 with RegDst=10, MemtoReg=10.
6. PERF_CNT_EN with CNT_W=4: retire 17 instructions -> instr_retired=1. Without the macro -> always 0.
